// File: rtl/bnn_acc_cfu.sv
// bnn_acc_cfu: stateful BNN accumulator/activation CFU behind the CFU-LI handshake.
// Each accepted request returns one response after a 1-cycle latency, held in a one-entry buffer.
// Backpressure: req_ready = !resp_valid | resp_ready. A response stalls until drained, and it can drain and refill in the same cycle.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_cfu                         CFU id; it is ignored because there is a single CFU
//   req_func                        {acc index[3:2], opcode[1:0]}
//   req_data0, req_data1            XNOR operands, or the threshold/load value in data0
//   resp_valid/resp_ready           response handshake
//   resp_status, resp_data          0 = OK and 1 = bad index; result
// Optional macro BNN_ACC_CFU_SATURATE_EN: ACC saturates at 2^ACC_W-1 instead of wrapping.
module bnn_acc_cfu #(
  parameter int unsigned CFU_LI_VERSION = 'h01_00,
  parameter int unsigned CFU_N_CFUS     = 1,
  parameter int unsigned CFU_CFU_ID_W   = 1,
  parameter int unsigned CFU_FUNC_ID_W  = 4,
  parameter int unsigned CFU_DATA_W     = 32,
  parameter int unsigned N_ACC          = 4,
  parameter int unsigned ACC_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [CFU_CFU_ID_W-1:0]  req_cfu,
  input  logic [CFU_FUNC_ID_W-1:0] req_func,
  input  logic [CFU_DATA_W-1:0]    req_data0,
  input  logic [CFU_DATA_W-1:0]    req_data1,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [2:0]               resp_status,
  output logic [CFU_DATA_W-1:0]    resp_data
);

  if (CFU_LI_VERSION != 'h01_00 || CFU_N_CFUS != 1 || CFU_FUNC_ID_W != 4 ||
      N_ACC < 1 || N_ACC > 4 || ACC_W < 7 || ACC_W > CFU_DATA_W) begin : g_param_err
    $fatal(1, "bnn_acc_cfu: unsupported parameter set");
  end

  localparam int unsigned PW = $clog2(CFU_DATA_W + 1);
  localparam logic [2:0]  N_ACC_L = 3'(N_ACC);

  typedef enum logic [1:0] {
    OP_ACC  = 2'd0,
    OP_LOAD = 2'd1,
    OP_ACT  = 2'd2,
    OP_READ = 2'd3
  } op_e;

  logic [ACC_W-1:0]      acc_q [N_ACC];
  logic                  resp_valid_q, resp_valid_d;
  logic [CFU_DATA_W-1:0] resp_data_q, resp_data_d;
  logic [2:0]            resp_status_q, resp_status_d;

  logic [1:0]            idx;
  op_e                   op;
  logic                  idx_ok, accept, acc_we;
  logic [ACC_W-1:0]      a, thr, acc_d, acc_new;
  logic [CFU_DATA_W-1:0] xnor_v, rdata;
  logic [PW-1:0]         pcnt;
  logic [2:0]            rstat;
  logic                  unused_cfu;

  assign unused_cfu = ^req_cfu;

  assign idx       = req_func[3:2];
  assign op        = op_e'(req_func[1:0]);
  assign idx_ok    = {1'b0, idx} < N_ACC_L;
  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;
  assign thr       = req_data0[ACC_W-1:0];
  assign xnor_v    = ~(req_data0 ^ req_data1);

  // Accumulator read mux. It is written as a loop so that N_ACC values that are not a power of 2 never index out of range.
  always_comb begin
    a = '0;
    for (int i = 0; i < int'(N_ACC); i++) begin
      if (idx == 2'(i)) a = acc_q[i];
    end
  end

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < int'(CFU_DATA_W); i++) begin
      pcnt = pcnt + PW'(xnor_v[i]);
    end
  end

`ifdef BNN_ACC_CFU_SATURATE_EN
  // The extra top bit catches the carry. Any carry clamps the result to all ones.
  logic [ACC_W:0] acc_sum;
  assign acc_sum = {1'b0, a} + (ACC_W + 1)'(pcnt);
  assign acc_new = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
  assign acc_new = a + ACC_W'(pcnt);
`endif

  always_comb begin
    acc_we = 1'b0;
    acc_d  = a;
    rdata  = '0;
    rstat  = 3'd0;
    if (!idx_ok) begin
      rstat = 3'd1;
    end else begin
      unique case (op)
        OP_ACC: begin
          acc_we = 1'b1;
          acc_d  = acc_new;
          rdata  = CFU_DATA_W'(acc_new);
        end
        OP_LOAD: begin
          acc_we = 1'b1;
          acc_d  = thr;
          rdata  = CFU_DATA_W'(a);
        end
        OP_ACT:  rdata = (a >= thr) ? CFU_DATA_W'(1) : '1;
        OP_READ: rdata = CFU_DATA_W'(a);
        default: rdata = '0;
      endcase
    end
  end

  // The response buffer loads on accept. Otherwise it empties once the response is consumed, and the data stays put.
  always_comb begin
    resp_valid_d  = resp_valid_q && !resp_ready;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    if (accept) begin
      resp_valid_d  = 1'b1;
      resp_data_d   = rdata;
      resp_status_d = rstat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
      for (int i = 0; i < int'(N_ACC); i++) acc_q[i] <= '0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      for (int i = 0; i < int'(N_ACC); i++) begin
        if (accept && acc_we && idx == 2'(i)) acc_q[i] <= acc_d;
      end
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_status = resp_status_q;

endmodule
